// File: rtl/lut_bank.sv
// lut_bank: runtime-programmable multi-table lookup memory.
// Holds NUM_TABLES tables of DEPTH entries of WIDTH bits, addressed as
// flat = sel*DEPTH + idx. After reset (or a reinit request) a sweep loads
// the default decoder constants one entry per cycle. Then it serves
// registered 1-cycle lookups and accepts run-time writes.
module lut_bank #(
    parameter int NUM_TABLES = 4,
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 8,
    localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reinit,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    output logic             init_done
);

    localparam int TOTAL  = NUM_TABLES * DEPTH;
    localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int FLAT_W = SEL_W + IDX_W;
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mem [TOTAL];

    logic [FLAT_W-1:0] rd_flat;
    logic [FLAT_W-1:0] wr_flat;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_fire;
    logic              wr_fire;
    logic              collide;

    // Default constant for a given flat sweep address.
    function automatic logic [WIDTH-1:0] default_entry(input logic [CNT_W-1:0] addr);
        int unsigned a;
        int unsigned t;
        int unsigned i;
        int unsigned v;
        a = 32'(addr);
        t = a / DEPTH_U;
        i = a % DEPTH_U;
        v = 0;
        case (t)
            0: if (i < 8) v = i + 1;
            1: begin
                if (i == 0)      v = 176;
                else if (i == 1) v = 7;
            end
            2: if (i == 0) v = 99;
            default: v = 0;
        endcase
        return WIDTH'(v);
    endfunction

    // Full-width flat addresses and range checks for both ports.
    always_comb begin
        rd_flat = FLAT_W'(rd_sel) * FLAT_W'(DEPTH) + FLAT_W'(rd_idx);
        wr_flat = FLAT_W'(wr_sel) * FLAT_W'(DEPTH) + FLAT_W'(wr_idx);
        rd_ok   = ({1'b0, rd_sel} < (SEL_W + 1)'(NUM_TABLES)) &&
                  ({1'b0, rd_idx} < (IDX_W + 1)'(DEPTH));
        wr_ok   = ({1'b0, wr_sel} < (SEL_W + 1)'(NUM_TABLES)) &&
                  ({1'b0, wr_idx} < (IDX_W + 1)'(DEPTH));
        rd_fire = rd_req && rd_ready;
        wr_fire = wr_en && (state == RUN) && wr_ok;
        collide = wr_fire && rd_ok && (rd_flat == wr_flat);
    end

    // Storage: default sweep in INIT, run-time writes in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                mem[cnt[ADDR_W-1:0]] <= default_entry(cnt);
            else if (wr_fire)
                mem[wr_flat[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            rd_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            wr_err    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            case (state)
                INIT: begin
                    wr_err <= wr_en;
                    if (cnt == CNT_W'(TOTAL - 1)) begin
                        state     <= RUN;
                        cnt       <= '0;
                        rd_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    wr_err <= wr_en && !wr_ok;
                    // Lookup sees pre-reinit contents; a colliding write is forwarded.
                    if (rd_fire) begin
                        rd_valid <= 1'b1;
                        rd_err   <= !rd_ok;
                        if (!rd_ok)
                            rd_data <= '0;
                        else if (collide)
                            rd_data <= wr_data;
                        else
                            rd_data <= mem[rd_flat[ADDR_W-1:0]];
                    end
                    if (reinit) begin
                        state     <= INIT;
                        cnt       <= '0;
                        rd_ready  <= 1'b0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_bank.sv
// Directed self-checking bench for lut_bank: scoreboard queue of expected
// lookup results, popped when rd_valid is seen. A second instance with
// three tables covers the out-of-range select boundary.
module tb_lut_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       reinit;
    logic       rd_req;
    logic [1:0] rd_sel;
    logic [4:0] rd_idx;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    logic       rd_ready, rd_valid, rd_err, wr_err, init_done;
    logic [7:0] rd_data;
    logic       d3_rd_ready, d3_rd_valid, d3_rd_err, d3_wr_err, d3_init_done;
    logic [7:0] d3_rd_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;
    exp_t q[$];

    lut_bank #(.NUM_TABLES(4), .DEPTH(32), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .reinit(reinit),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_err(wr_err), .init_done(init_done)
    );

    lut_bank #(.NUM_TABLES(3), .DEPTH(32), .WIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .reinit(reinit),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_ready(d3_rd_ready), .rd_valid(d3_rd_valid), .rd_data(d3_rd_data), .rd_err(d3_rd_err),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_err(d3_wr_err), .init_done(d3_init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compares each rd_valid pulse against the queue head.
    always @(negedge clk) begin
        logic exp_now;
        exp_now = (q.size() > 0) && (q[0].due == cyc);
        if (rd_valid || exp_now) begin
            check("rd_valid_timing", 32'(rd_valid), 32'(exp_now));
            if (rd_valid && exp_now) begin
                check("rd_data", 32'(rd_data), 32'(q[0].data));
                check("rd_err", 32'(rd_err), 32'(q[0].err));
            end
            if (exp_now) void'(q.pop_front());
        end
    end

    task automatic lookup(input logic [1:0] s, input logic [4:0] i,
                          input logic [7:0] d, input logic e);
        rd_req = 1'b1;
        rd_sel = s;
        rd_idx = i;
        q.push_back('{data: d, err: e, due: cyc + 1});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic write(input logic [1:0] s, input logic [4:0] i, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_idx  = i;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n3;
        reset = 1'b1; reinit = 1'b0; rd_req = 1'b0; rd_sel = '0; rd_idx = '0;
        wr_en = 1'b0; wr_sel = '0; wr_idx = '0; wr_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rd_ready", 32'(rd_ready), 0);
        check("reset_init_done", 32'(init_done), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        check("reset_rd_err", 32'(rd_err), 0);
        check("reset_wr_err", 32'(wr_err), 0);
        reset = 1'b0;

        // INIT length, with a dropped write at INIT cycle 10
        n = 0; n3 = 0;
        while (!init_done && n < 300) begin
            @(negedge clk);
            n++;
            if (d3_init_done && n3 == 0) n3 = n;
            if (n == 10) write_start();
            if (n == 11) begin
                check("init_wr_err_pulse", 32'(wr_err), 1);
                wr_en = 1'b0;
            end
            if (n == 12) check("init_wr_err_clear", 32'(wr_err), 0);
            if (!init_done && rd_ready) check("rd_ready_in_init", 32'(rd_ready), 0);
        end
        check("init_len", 32'(n), 128);
        check("init_len_3tbl", 32'(n3), 96);
        check("run_rd_ready", 32'(rd_ready), 1);

        lookup(2'd0, 5'd3, 8'd4, 1'b0);
        lookup(2'd1, 5'd0, 8'd176, 1'b0);
        lookup(2'd1, 5'd1, 8'd7, 1'b0);
        lookup(2'd2, 5'd0, 8'd99, 1'b0);
        lookup(2'd3, 5'd5, 8'd0, 1'b0);
        check("d3_oor_valid", 32'(d3_rd_valid), 1);
        check("d3_oor_err", 32'(d3_rd_err), 1);
        check("d3_oor_data", 32'(d3_rd_data), 0);
        @(negedge clk);
        check("d3_err_held", 32'(d3_rd_err), 1);
        check("d3_valid_drop", 32'(d3_rd_valid), 0);

        // write dropped during INIT must not have landed
        lookup(2'd0, 5'd0, 8'd1, 1'b0);

        write(2'd2, 5'd4, 8'h5A);
        check("wr_err_inrange", 32'(wr_err), 0);
        lookup(2'd2, 5'd4, 8'h5A, 1'b0);
        @(negedge clk);
        check("rd_data_held", 32'(rd_data), 32'h5A);

        // same-cycle write and lookup of one address: write-first
        wr_en = 1'b1; wr_sel = 2'd0; wr_idx = 5'd9; wr_data = 8'hEE;
        lookup(2'd0, 5'd9, 8'hEE, 1'b0);
        wr_en = 1'b0;
        lookup(2'd0, 5'd9, 8'hEE, 1'b0);

        // sel=3 is legal for 4 tables, out of range for 3
        write(2'd3, 5'd1, 8'h11);
        check("wr_err_sel3_4tbl", 32'(wr_err), 0);
        check("wr_err_sel3_3tbl", 32'(d3_wr_err), 1);
        lookup(2'd3, 5'd1, 8'h11, 1'b0);

        // reinit with same-cycle lookup sees pre-reinit contents
        write(2'd0, 5'd0, 8'h33);
        reinit = 1'b1;
        lookup(2'd0, 5'd0, 8'h33, 1'b0);
        reinit = 1'b0;
        check("reinit_rd_ready", 32'(rd_ready), 0);
        check("reinit_init_done", 32'(init_done), 0);
        n = 0;
        while (!rd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reinit_len", 32'(n), 128);
        lookup(2'd0, 5'd0, 8'd1, 1'b0);
        lookup(2'd3, 5'd1, 8'd0, 1'b0);

        // reset during INIT restarts the sweep
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midinit_reset_done", 32'(init_done), 0);
        check("midinit_reset_ready", 32'(rd_ready), 0);
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("restart_init_len", 32'(n), 128);
        lookup(2'd1, 5'd1, 8'd7, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic write_start();
        wr_en   = 1'b1;
        wr_sel  = 2'd0;
        wr_idx  = 5'd0;
        wr_data = 8'hFF;
    endtask

endmodule
